pipe_trace_tracker: RTL and testbench
=====================================

Name: pipe_trace_tracker

Overview:
Synthesizable instruction-trace tracker for the pipelined CPU verification flow. It mirrors the fetched instruction stream through a DEPTH-deep shadow pipeline, with stall and flush support, so per-stage golden checks can align on the retiring instruction. It also owns run control: start, drain after end-of-program, cycle-budget timeout, and a sticky pass/fail verdict. It sits beside Pipeline_CPU and is driven from the fetch side, plus a mismatch flag from the state comparator.

Parameters:
WIDTH, 32, instruction word width
DEPTH, 4, number of shadow stages (stage 0 = newest, stage DEPTH-1 = retiring)
STALL_POS, 1, stages 0..STALL_POS hold on stall; stage STALL_POS+1 receives a bubble
FLUSH_POS, 1, stages 0..FLUSH_POS are cleared on flush
DRAIN_CYCLES, 5, cycles spent in DRAIN after end-of-program detection (must be >= DEPTH)
MAX_CYCLES, 15, RUN+DRAIN cycle budget before timeout
FAIL_HOLD, 2, cycles spent in FAIL before DONE

Ports:
clk_i  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_i  in  1  pulse; begins a run from IDLE or DONE
instr_i  in  WIDTH  fetched instruction
instr_valid_i  in  1  instr_i is valid this cycle
stall_i  in  1  hazard stall
flush_i  in  1  branch flush
mismatch_i  in  1  comparator reports a register/memory mismatch
stage_instr_o  out  DEPTH*WIDTH  flattened stage contents; stage k at [k*WIDTH +: WIDTH]
stage_valid_o  out  DEPTH  per-stage valid
retire_instr_o  out  WIDTH  stage DEPTH-1 instruction
retire_valid_o  out  1  stage DEPTH-1 valid
state_o  out  3  FSM state encoding
cycle_cnt_o  out  8  cycles since start
done_o  out  1  run finished; held until next start
pass_o  out  1  valid only when done_o=1
timeout_o  out  1  sticky; run ended by budget exhaustion

Behaviour:
- Reset: all stages 0 and invalid, state IDLE, cycle_cnt 0, done/pass/timeout 0. Reset mid-run aborts immediately with no verdict.
- FSM IDLE(0) -> RUN(1) on start_i. RUN -> DRAIN(2) when instr_valid_i=1 and instr_i==0. RUN/DRAIN -> FAIL(3) on mismatch_i, or when cycle_cnt reaches MAX_CYCLES-1 without finishing (sets timeout_o). DRAIN -> DONE(4) after DRAIN_CYCLES cycles with pass_o=1. FAIL -> DONE after FAIL_HOLD cycles with pass_o=0. DONE -> RUN on start_i, which clears stages, counters, timeout and done.
- Priority: mismatch > timeout > end-of-program. mismatch_i is ignored outside RUN/DRAIN.
- Shift (RUN/DRAIN, no stall/flush): stage0 <= instr_i with valid = instr_valid_i (forced to a bubble in DRAIN and for the zero word); stage k <= stage k-1. One-cycle latency per stage; an instruction retires DEPTH cycles after capture.
- Stall: stages 0..STALL_POS hold; stage STALL_POS+1 receives a bubble (0, invalid); later stages shift.
- Flush: stages 0..FLUSH_POS become bubbles; later stages shift. Flush and stall together: flush wins and stalled stages are cleared.
- Outside RUN/DRAIN: stages frozen.
- cycle_cnt_o increments each cycle in RUN/DRAIN and saturates at 255. DRAIN counter is independent.

Optional Feature:
Macro PIPE_TRACE_STATS_EN. When defined, adds outputs stall_cnt_o[7:0], flush_cnt_o[7:0] and retired_cnt_o[7:0] (valid retirements). All three saturate and clear on start_i. When undefined, these ports and counters are absent and the rest of the behaviour is identical.

Decomposition:
- Package pipe_trace_pkg holds:
  - state enum: IDLE, RUN, DRAIN, FAIL, DONE
  - NOP_WORD = 32'd0
  - default parameter constants
- Sub-module pipe_trace_stage: one WIDTH+1-bit register with hold, bubble and load controls. It is instantiated DEPTH times in a generate loop.

Test Plan:
- Start, then feed 3 valid nonzero words A,B,C followed by 0 -> A retires 4 cycles after capture; DRAIN lasts 5 cycles; done_o=1, pass_o=1.
- stall_i high for 1 cycle after B -> B held in stage 1; a bubble appears in stage 2; retire order A,bubble,B,C.
- flush_i with stall_i in the same cycle -> stages 0-1 invalid next cycle; stage 2-3 contents shift normally.
- mismatch_i pulsed in cycle 6 -> state FAIL for 2 cycles, then DONE with pass_o=0, timeout_o=0.
- Never send 0 -> at cycle 14 go to FAIL with timeout_o=1; then DONE, pass_o=0.
- Drop rst_n mid-DRAIN -> all outputs zero asynchronously; a new start_i runs cleanly.

Source files
------------

// File: rtl/pipe_trace_pkg.sv
// Shared types and defaults for the instruction-trace tracker.
// State encoding, NOP word, default parameters and a saturating counter helper.
package pipe_trace_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        FAIL  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [31:0] NOP_WORD = 32'd0;

    localparam int DEF_WIDTH        = 32;
    localparam int DEF_DEPTH        = 4;
    localparam int DEF_STALL_POS    = 1;
    localparam int DEF_FLUSH_POS    = 1;
    localparam int DEF_DRAIN_CYCLES = 5;
    localparam int DEF_MAX_CYCLES   = 15;
    localparam int DEF_FAIL_HOLD    = 2;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pipe_trace_stage.sv
// One shadow-pipeline stage: a {valid, instr} register with bubble and hold controls.
// Latency: one cycle. Backpressure: hold keeps contents; bubble overrides hold and clears.
// Control priority: bubble > hold > load.
module pipe_trace_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             bubble,
    input  logic [WIDTH-1:0] d_instr,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q_instr,
    output logic             q_valid
);

    logic [WIDTH:0] stage_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else if (bubble) begin
            stage_q <= '0;
        end else if (!hold) begin
            stage_q <= {d_valid, d_instr};
        end
    end

    assign q_valid = stage_q[WIDTH];
    assign q_instr = stage_q[WIDTH-1:0];

endmodule

// File: rtl/pipe_trace_tracker.sv
// Instruction-trace tracker: DEPTH-deep shadow pipeline plus run-control FSM with a sticky verdict.
// Latency: an instruction captured in RUN reaches the retire stage DEPTH cycles later.
// Backpressure: none; stall_i holds the front stages. PIPE_TRACE_STATS_EN adds stall/flush/retire counters.
module pipe_trace_tracker
    import pipe_trace_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int STALL_POS    = DEF_STALL_POS,
    parameter int FLUSH_POS    = DEF_FLUSH_POS,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int MAX_CYCLES   = DEF_MAX_CYCLES,
    parameter int FAIL_HOLD    = DEF_FAIL_HOLD
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [WIDTH-1:0]       instr_i,
    input  logic                   instr_valid_i,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic                   mismatch_i,
    output logic [DEPTH*WIDTH-1:0] stage_instr_o,
    output logic [DEPTH-1:0]       stage_valid_o,
    output logic [WIDTH-1:0]       retire_instr_o,
    output logic                   retire_valid_o,
    output logic [2:0]             state_o,
    output logic [7:0]             cycle_cnt_o,
    output logic                   done_o,
    output logic                   pass_o,
    output logic                   timeout_o
`ifdef PIPE_TRACE_STATS_EN
    ,
    output logic [7:0]             stall_cnt_o,
    output logic [7:0]             flush_cnt_o,
    output logic [7:0]             retired_cnt_o
`endif
);

    localparam logic [7:0] MAX_LAST   = 8'(MAX_CYCLES - 1);
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
    localparam logic [7:0] FAIL_LAST  = 8'(FAIL_HOLD - 1);

    state_t     state;
    logic [7:0] cycle_cnt;
    logic [7:0] phase_cnt;
    logic       done;
    logic       pass;
    logic       timeout;

    logic active;
    logic clr;
    logic eop;
    logic in_valid;

    logic             hold_s   [DEPTH];
    logic             bubble_s [DEPTH];
    logic [WIDTH-1:0] d_instr  [DEPTH];
    logic             d_valid  [DEPTH];
    logic [WIDTH-1:0] instr_q  [DEPTH];
    logic             valid_q  [DEPTH];

    assign active   = (state == RUN) || (state == DRAIN);
    assign clr      = start_i && ((state == IDLE) || (state == DONE));
    assign eop      = instr_valid_i && (instr_i == WIDTH'(NOP_WORD));
    // The end-of-program word and anything fetched during DRAIN enter as bubbles.
    assign in_valid = (state == RUN) && instr_valid_i && (instr_i != WIDTH'(NOP_WORD));

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign d_instr[k] = in_valid ? instr_i : '0;
            assign d_valid[k] = in_valid;
        end else begin : g_body
            assign d_instr[k] = instr_q[k-1];
            assign d_valid[k] = valid_q[k-1];
        end

        // Flush overrides stall entirely: the stage behind the stall point shifts normally.
        assign bubble_s[k] = clr
                           || (active && flush_i && (k <= FLUSH_POS))
                           || (active && !flush_i && stall_i && (k == STALL_POS + 1));
        assign hold_s[k]   = !clr && (!active || (!flush_i && stall_i && (k <= STALL_POS)));

        pipe_trace_stage #(.WIDTH(WIDTH)) u_stage (
            .clk_i   (clk_i),
            .rst_n   (rst_n),
            .hold    (hold_s[k]),
            .bubble  (bubble_s[k]),
            .d_instr (d_instr[k]),
            .d_valid (d_valid[k]),
            .q_instr (instr_q[k]),
            .q_valid (valid_q[k])
        );

        assign stage_instr_o[k*WIDTH +: WIDTH] = instr_q[k];
        assign stage_valid_o[k]                = valid_q[k];
    end

    assign retire_instr_o = instr_q[DEPTH-1];
    assign retire_valid_o = valid_q[DEPTH-1];

    // Priority inside RUN/DRAIN: mismatch, then budget timeout, then end-of-program/drain.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cycle_cnt <= '0;
            phase_cnt <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state     <= RUN;
                        cycle_cnt <= '0;
                        phase_cnt <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        timeout   <= 1'b0;
                    end
                end
                RUN, DRAIN: begin
                    cycle_cnt <= sat_inc(cycle_cnt);
                    if (mismatch_i) begin
                        state     <= FAIL;
                        phase_cnt <= '0;
                    end else if (cycle_cnt == MAX_LAST) begin
                        state     <= FAIL;
                        phase_cnt <= '0;
                        timeout   <= 1'b1;
                    end else if (state == RUN) begin
                        if (eop) begin
                            state     <= DRAIN;
                            phase_cnt <= '0;
                        end
                    end else if (phase_cnt == DRAIN_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end
                FAIL: begin
                    if (phase_cnt == FAIL_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign state_o     = state;
    assign cycle_cnt_o = cycle_cnt;
    assign done_o      = done;
    assign pass_o      = pass;
    assign timeout_o   = timeout;

`ifdef PIPE_TRACE_STATS_EN
    logic [7:0] stall_cnt;
    logic [7:0] flush_cnt;
    logic [7:0] retired_cnt;

    // A retirement is a valid word loaded into the last stage.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            retired_cnt <= '0;
        end else if (clr) begin
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            retired_cnt <= '0;
        end else if (active) begin
            if (stall_i) stall_cnt <= sat_inc(stall_cnt);
            if (flush_i) flush_cnt <= sat_inc(flush_cnt);
            if (!hold_s[DEPTH-1] && !bubble_s[DEPTH-1] && d_valid[DEPTH-1])
                retired_cnt <= sat_inc(retired_cnt);
        end
    end

    assign stall_cnt_o   = stall_cnt;
    assign flush_cnt_o   = flush_cnt;
    assign retired_cnt_o = retired_cnt;
`endif

endmodule

// File: tb/tb_pipe_trace_tracker.sv
// Directed bench for pipe_trace_tracker: run control, stall/flush shadow pipeline, timeout, reset abort.
// Retiring words are scored against a queue filled as stimulus is driven.
module tb_pipe_trace_tracker;

    logic          clk_i;
    logic          rst_n;
    logic          start_i;
    logic [31:0]   instr_i;
    logic          instr_valid_i;
    logic          stall_i;
    logic          flush_i;
    logic          mismatch_i;
    logic [127:0]  stage_instr_o;
    logic [3:0]    stage_valid_o;
    logic [31:0]   retire_instr_o;
    logic          retire_valid_o;
    logic [2:0]    state_o;
    logic [7:0]    cycle_cnt_o;
    logic          done_o;
    logic          pass_o;
    logic          timeout_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_w;
    logic        mon_en = 1'b0;

    localparam logic [31:0] WA = 32'hA000_0001;
    localparam logic [31:0] WB = 32'hB000_0002;
    localparam logic [31:0] WC = 32'hC000_0003;
    localparam logic [31:0] WD = 32'hD000_0004;
    localparam logic [31:0] WE = 32'hE000_0005;

    pipe_trace_tracker dut (
        .clk_i          (clk_i),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .instr_i        (instr_i),
        .instr_valid_i  (instr_valid_i),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .mismatch_i     (mismatch_i),
        .stage_instr_o  (stage_instr_o),
        .stage_valid_o  (stage_valid_o),
        .retire_instr_o (retire_instr_o),
        .retire_valid_o (retire_valid_o),
        .state_o        (state_o),
        .cycle_cnt_o    (cycle_cnt_o),
        .done_o         (done_o),
        .pass_o         (pass_o),
        .timeout_o      (timeout_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [31:0] wseq(input int i);
        return 32'h0000_0100 + 32'(i);
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic feed(input logic [31:0] w, input bit push);
        instr_i       = w;
        instr_valid_i = 1'b1;
        if (push) sb_q.push_back(w);
    endtask

    task automatic idle_in();
        instr_i       = '0;
        instr_valid_i = 1'b0;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Each new valid word at the retire stage must be the oldest expected word.
    always @(negedge clk_i) begin
        if (mon_en && rst_n && retire_valid_o) begin
            checks++;
            assert (sb_q.size() != 0)
            else begin
                errors++;
                $error("FAIL sb_underflow: observed retire %0h expected none", retire_instr_o);
            end
            if (sb_q.size() != 0) begin
                exp_w = sb_q.pop_front();
                checks++;
                assert (retire_instr_o === exp_w)
                else begin
                    errors++;
                    $error("FAIL sb_retire: observed %0h expected %0h", retire_instr_o, exp_w);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; start_i = 1'b0; instr_i = '0; instr_valid_i = 1'b0;
        stall_i = 1'b0; flush_i = 1'b0; mismatch_i = 1'b0;
        #12;
        chk("rst_state", state_o, 3'd0);
        chk("rst_valid", stage_valid_o, 4'b0000);
        chk("rst_instr", stage_instr_o, 128'd0);
        chk("rst_cnt", cycle_cnt_o, 8'd0);
        chk("rst_verdict", {done_o, pass_o, timeout_o}, 3'b000);
        rst_n = 1'b1;

        // Basic run: A,B,C then end-of-program and a 5-cycle drain.
        do_start();
        chk("t1_run", state_o, 3'd1);
        chk("t1_cnt0", cycle_cnt_o, 8'd0);
        mon_en = 1'b1;
        feed(WA, 1); tick();
        chk("t1_v_a", stage_valid_o, 4'b0001);
        chk("t1_s0_a", stage_instr_o[31:0], WA);
        feed(WB, 1); tick();
        feed(WC, 1); tick();
        chk("t1_v_abc", stage_valid_o, 4'b0111);
        feed(32'd0, 0); tick();
        idle_in();
        chk("t1_drain", state_o, 3'd2);
        chk("t1_v_eop", stage_valid_o, 4'b1110);
        chk("t1_ret_a", {retire_valid_o, retire_instr_o}, {1'b1, WA});
        repeat (4) tick();
        chk("t1_drain_len", state_o, 3'd2);
        tick();
        chk("t1_done", state_o, 3'd4);
        chk("t1_verdict", {done_o, pass_o, timeout_o}, 3'b110);
        chk("t1_cnt", cycle_cnt_o, 8'd9);
        mismatch_i = 1'b1; tick(); mismatch_i = 1'b0;
        chk("t1_mm_ignored", {state_o, pass_o}, {3'd4, 1'b1});
        chk("t1_sb_empty", sb_q.size(), 0);

        // Stall one cycle once B sits in stage 1: retire order A, bubble, B, C.
        do_start();
        chk("t2_clear", {done_o, pass_o, stage_valid_o, cycle_cnt_o}, {2'b00, 4'b0000, 8'd0});
        feed(WA, 1); tick();
        feed(WB, 1); tick();
        feed(WC, 1); tick();
        idle_in(); stall_i = 1'b1; tick(); stall_i = 1'b0;
        chk("t2_v_stall", stage_valid_o, 4'b1011);
        chk("t2_s1_b", stage_instr_o[63:32], WB);
        chk("t2_s2_bub", stage_instr_o[95:64], 32'd0);
        feed(32'd0, 0); tick();
        idle_in();
        chk("t2_v_eop", stage_valid_o, 4'b0110);
        chk("t2_ret_bub", retire_valid_o, 1'b0);
        repeat (5) tick();
        chk("t2_done", {state_o, pass_o}, {3'd4, 1'b1});
        chk("t2_cnt", cycle_cnt_o, 8'd10);
        chk("t2_sb_empty", sb_q.size(), 0);

        // Flush and stall together: front two stages cleared, back two shift.
        do_start();
        feed(WA, 1); tick();
        feed(WB, 1); tick();
        feed(WC, 1); tick();
        feed(WD, 0); tick();
        chk("t3_v_full", stage_valid_o, 4'b1111);
        feed(WE, 0); flush_i = 1'b1; stall_i = 1'b1; tick();
        flush_i = 1'b0; stall_i = 1'b0;
        chk("t3_v_flush", stage_valid_o, 4'b1100);
        chk("t3_s2_c", stage_instr_o[95:64], WC);
        chk("t3_s3_b", stage_instr_o[127:96], WB);
        feed(32'd0, 0); tick();
        idle_in();
        chk("t3_v_eop", stage_valid_o, 4'b1000);
        repeat (5) tick();
        chk("t3_done", {state_o, pass_o}, {3'd4, 1'b1});
        chk("t3_cnt", cycle_cnt_o, 8'd11);
        chk("t3_sb_empty", sb_q.size(), 0);

        // Mismatch in cycle 6: two cycles of FAIL, then DONE without a pass.
        mon_en = 1'b0;
        do_start();
        for (int i = 0; i < 6; i++) begin
            feed(wseq(i), 0); tick();
        end
        chk("t4_cnt6", cycle_cnt_o, 8'd6);
        feed(wseq(6), 0); mismatch_i = 1'b1; tick(); mismatch_i = 1'b0;
        feed(wseq(7), 0);
        chk("t4_fail", state_o, 3'd3);
        chk("t4_s0", stage_instr_o[31:0], wseq(6));
        chk("t4_s3", stage_instr_o[127:96], wseq(3));
        tick();
        chk("t4_fail_hold", state_o, 3'd3);
        chk("t4_frozen", stage_instr_o[31:0], wseq(6));
        tick();
        idle_in();
        chk("t4_done", state_o, 3'd4);
        chk("t4_verdict", {done_o, pass_o, timeout_o}, 3'b100);
        chk("t4_frozen_s3", stage_instr_o[127:96], wseq(3));
        chk("t4_cnt", cycle_cnt_o, 8'd7);

        // Never send the end word: budget runs out at cycle 14.
        do_start();
        for (int i = 0; i < 14; i++) begin
            feed(wseq(i), 0); tick();
        end
        chk("t5_run14", {state_o, cycle_cnt_o}, {3'd1, 8'd14});
        feed(wseq(14), 0); tick();
        idle_in();
        chk("t5_fail", state_o, 3'd3);
        chk("t5_timeout", timeout_o, 1'b1);
        chk("t5_cnt", cycle_cnt_o, 8'd15);
        repeat (2) tick();
        chk("t5_done", state_o, 3'd4);
        chk("t5_verdict", {done_o, pass_o, timeout_o}, 3'b101);

        // Reset in the middle of DRAIN aborts the run; a fresh start runs cleanly.
        do_start();
        chk("t6_clear", {done_o, timeout_o}, 2'b00);
        feed(WA, 0); tick();
        feed(32'd0, 0); tick();
        idle_in();
        chk("t6_drain", state_o, 3'd2);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_state", state_o, 3'd0);
        chk("t6_rst_stages", {stage_valid_o, stage_instr_o}, 132'd0);
        chk("t6_rst_outs", {cycle_cnt_o, done_o, pass_o, timeout_o, retire_valid_o}, 12'd0);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;
        do_start();
        chk("t6_run", state_o, 3'd1);
        feed(WA, 1); tick();
        feed(32'd0, 0); tick();
        idle_in();
        repeat (5) tick();
        chk("t6_done", {state_o, done_o, pass_o}, {3'd4, 2'b11});
        chk("t6_cnt", cycle_cnt_o, 8'd7);
        chk("t6_sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
